nn_score_reader: RTL and testbench
==================================

Name: nn_score_reader

Overview:
- Consumer end of the accelerator's 32-bit `values` output stream.
- Accepts one frame of NUM_CLASSES signed class scores per inference over a valid/ready handshake and buffers them.
- Computes the running argmax and presents the predicted digit, its score and a framing error flag on an output valid/ready handshake.
- Sits between nn_accelerator_top and the host/readout logic.

Parameters:
- DATA_W, 32, width of one signed score (two's complement).
- NUM_CLASSES, 10, scores per frame (MNIST digits 0-9).
- IDX_W, 4, class index width; must satisfy 2^IDX_W >= NUM_CLASSES.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  score beat valid.
- in_data  in  DATA_W  signed score (accelerator `values`).
- in_last  in  1  marks the final beat of a frame.
- in_ready  out  1  reader can accept a beat.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_class  out  IDX_W  argmax index.
- out_score  out  DATA_W  maximum score.
- out_error  out  1  frame length mismatch detected.
- rd_idx  in  IDX_W  score buffer read index.
- rd_data  out  DATA_W  buffered score at rd_idx (combinational read).
- frame_count  out  CNT_W  results delivered since reset.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to COLLECT; beat count, max, index, error flag and frame_count go to 0.
  - in_ready=1 in the first cycle after reset is released; out_valid=0, out_class=0, out_score=0, out_error=0.
  - The score buffer is cleared to 0.
  - Reset mid-frame or mid-HOLD discards the partial frame or pending result with no output.
- States: COLLECT, HOLD.
- COLLECT:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - The beat is written to buf[count]; count increments.
  - Beat 0 unconditionally loads max=in_data, idx=0.
  - Later beats replace max/idx only if in_data > max (signed, strict). Ties keep the lower index.
- Frame end, on an accepted beat:
  - If in_last=1, or count reaches NUM_CLASSES-1 before increment, go to HOLD on the next edge.
  - out_error=1 if in_last was asserted on a beat other than index NUM_CLASSES-1 (short frame), or not asserted on beat NUM_CLASSES-1 (long frame).
  - For a long frame, the reader stops accepting after beat NUM_CLASSES-1; the remaining upstream beats stay stalled and begin the next frame.
  - Short-frame argmax covers only the beats received; unwritten buffer entries keep stale values.
- Latency: out_valid=1 in the cycle after the final accepted beat.
- HOLD:
  - in_ready=0; out_valid=1; out_class, out_score, out_error and the buffer are stable.
  - On out_valid && out_ready: frame_count increments (wraps at 2^CNT_W-1 to 0); count, max and error are cleared; return to COLLECT.
  - in_ready=1 from the next cycle, so there is one bubble cycle per frame.
  - out_valid is held indefinitely until accepted; no result is dropped.
- rd_data:
  - Combinational buf[rd_idx].
  - rd_idx >= NUM_CLASSES returns 0.
  - Reads during COLLECT may return stale or partial data; reads during HOLD are guaranteed stable.
- No simultaneous accept and result in the same cycle, because in_ready=0 in HOLD.

Decomposition:
- Shared package nn_pkg:
  - NN_DATA_W=32, NN_NUM_CLASSES=10, NN_IDX_W=4.
  - state enum {ST_COLLECT, ST_HOLD}.
  - These are shared with nn_accelerator_top and the frame source.
- One natural sub-module: nn_argmax_update, the combinational signed compare/select of (max, idx) against (in_data, count), with the first-beat load.
- Buffer, FSM and counters stay in nn_score_reader.

Test Plan:
- Scores [5,-3,12,7,0,1,2,3,4,11], in_last on beat 9 → out_valid one cycle after beat 9; out_class=2, out_score=12, out_error=0, frame_count=1.
- All-negative frame [-9,-2,-8,-2,-7,-5,-6,-4,-3,-10] → out_class=1 (tie with index 3 goes to lower), out_score=-2 (0xFFFFFFFE).
- Hold out_ready=0 for 20 cycles after a result → out_valid, class and score stable, in_ready=0 throughout; on release, in_ready=1 the next cycle.
- in_last on beat 4 with scores [0,0,50,0,0] → out_class=2, out_error=1.
- 11-beat upstream burst with no in_last → result after beat 9 with out_error=1; beat 10 is held until the handshake, then accepted as beat 0 of the next frame.
- Drive rst=0 for one edge after 6 beats → in_ready=1, out_valid=0, frame_count=0; next full frame gives the correct result with no leftover max.
- Read all rd_idx 0-15 in HOLD → buffered scores for 0-9, zero for 10-15.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the classifier output path.
// The accelerator top and the frame source use the same definitions.
package nn_pkg;

   localparam int NN_DATA_W      = 32;
   localparam int NN_NUM_CLASSES = 10;
   localparam int NN_IDX_W       = 4;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_e;

endpackage

// File: rtl/nn_score_reader_if.sv
// Score input stream and result output stream of the score reader.
// The slave modport is the reader side; master is the environment side.
interface nn_score_reader_if
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int IDX_W  = NN_IDX_W
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  out_class;
   logic [DATA_W-1:0] out_score;
   logic              out_error;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_class, out_score, out_error
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_class, out_score, out_error
   );
endinterface

// File: rtl/nn_argmax_update.sv
// Combinational running-argmax step: signed strict compare, first beat loads.
// Strict compare means ties keep the earlier (lower) index.
module nn_argmax_update
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int IDX_W  = NN_IDX_W
) (
   input  logic                     first_i,
   input  logic signed [DATA_W-1:0] max_i,
   input  logic        [IDX_W-1:0]  idx_i,
   input  logic signed [DATA_W-1:0] data_i,
   input  logic        [IDX_W-1:0]  count_i,
   output logic signed [DATA_W-1:0] max_o,
   output logic        [IDX_W-1:0]  idx_o
);

   always_comb begin
      max_o = max_i;
      idx_o = idx_i;
      if (first_i || (data_i > max_i)) begin
         max_o = data_i;
         idx_o = count_i;
      end
   end

endmodule

// File: rtl/nn_score_reader.sv
// Buffers one frame of class scores, tracks the argmax and holds the result
// until the downstream handshake; one bubble cycle separates frames.
module nn_score_reader
   import nn_pkg::*;
#(
   parameter int DATA_W      = NN_DATA_W,
   parameter int NUM_CLASSES = NN_NUM_CLASSES,
   parameter int IDX_W       = NN_IDX_W,
   parameter int CNT_W       = 16
) (
   input  logic                 clock,
   input  logic                 rst,
   nn_score_reader_if.slave     bus,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic [DATA_W-1:0]    rd_data,
   output logic [CNT_W-1:0]     frame_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
   localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_CLASSES);

   state_e                     state_q;
   logic        [IDX_W-1:0]    count_q;
   logic signed [DATA_W-1:0]   max_q;
   logic        [IDX_W-1:0]    idx_q;
   logic                       err_q;
   logic        [CNT_W-1:0]    fc_q;
   logic signed [DATA_W-1:0]   buf_q [NUM_CLASSES];

   logic signed [DATA_W-1:0]   max_d;
   logic        [IDX_W-1:0]    idx_d;
   logic                       accept;
   logic                       at_last;

   assign accept  = bus.in_valid && (state_q == ST_COLLECT);
   assign at_last = (count_q == LAST_IDX);

   nn_argmax_update #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_argmax (
      .first_i (count_q == '0),
      .max_i   (max_q),
      .idx_i   (idx_q),
      .data_i  ($signed(bus.in_data)),
      .count_i (count_q),
      .max_o   (max_d),
      .idx_o   (idx_d)
   );

   always_ff @(posedge clock) begin
      if (!rst) begin
         state_q <= ST_COLLECT;
         count_q <= '0;
         max_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         fc_q    <= '0;
         for (int i = 0; i < NUM_CLASSES; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (accept) begin
                  buf_q[count_q] <= $signed(bus.in_data);
                  max_q          <= max_d;
                  idx_q          <= idx_d;
                  count_q        <= count_q + 1'b1;
                  // A frame ends on in_last or on the last slot, whichever comes first.
                  if (bus.in_last || at_last) begin
                     state_q <= ST_HOLD;
                     err_q   <= (bus.in_last != at_last);
                  end
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  fc_q    <= fc_q + 1'b1;
                  count_q <= '0;
                  max_q   <= '0;
                  idx_q   <= '0;
                  err_q   <= 1'b0;
                  state_q <= ST_COLLECT;
               end
            end
            default: state_q <= ST_COLLECT;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == ST_COLLECT);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_class = idx_q;
   assign bus.out_score = max_q;
   assign bus.out_error = err_q;
   assign frame_count   = fc_q;

   assign rd_data = (rd_idx < NUM_IDX) ? buf_q[rd_idx] : '0;

endmodule

// File: tb/tb_nn_score_reader.sv
// Directed self-checking bench for nn_score_reader.
module tb_nn_score_reader;
   import nn_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  rd_idx;
   logic [31:0] rd_data;
   logic [15:0] frame_count;

   int checks;
   int failures;
   int exp_fc;
   int frame [16];

   nn_score_reader_if #(.DATA_W(32), .IDX_W(4)) bus ();

   nn_score_reader #(
      .DATA_W      (32),
      .NUM_CLASSES (10),
      .IDX_W       (4),
      .CNT_W       (16)
   ) dut (
      .clock       (clk),
      .rst         (rst),
      .bus         (bus),
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
      .frame_count (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send_beat(input logic [31:0] d, input logic l);
      int waited;
      waited = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (bus.in_ready !== 1'b1 && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      if (waited >= 100) begin
         checks++; failures++;
         $display("FAIL send_beat_timeout in_ready=%b required=1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_frame(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         send_beat(32'(frame[i]), with_last && (i == n - 1));
      end
   endtask

   task automatic accept_result();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      exp_fc++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_handshake in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.out_class !== 4'd0 || bus.out_score !== 32'd0 || bus.out_error !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs class=%0d score=%h err=%b required 0/0/0", bus.out_class, bus.out_score, bus.out_error);
      end
      checks++;
      if (frame_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_frame_count got=%0d required=0", frame_count);
      end
      rd_idx = 4'd3; #1;
      checks++;
      if (rd_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_buffer got=%h required=0", rd_data);
      end
   endtask

   task automatic test_basic();
      frame = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11, 0, 0, 0, 0, 0, 0};
      send_frame(10, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL basic_latency out_valid=%b in_ready=%b required 1/0", bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.out_class !== 4'd2 || bus.out_score !== 32'd12 || bus.out_error !== 1'b0) begin
         failures++;
         $display("FAIL basic_result class=%0d score=%h err=%b required 2/0000000c/0", bus.out_class, bus.out_score, bus.out_error);
      end
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i); #1;
         checks++;
         if (rd_data !== ((i < 10) ? 32'(frame[i]) : 32'd0)) begin
            failures++;
            $display("FAIL readback idx=%0d got=%h required=%h", i, rd_data, (i < 10) ? 32'(frame[i]) : 32'd0);
         end
      end
      accept_result();
      checks++;
      if (frame_count !== 16'(exp_fc) || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_accept fc=%0d in_ready=%b out_valid=%b required %0d/1/0", frame_count, bus.in_ready, bus.out_valid, exp_fc);
      end
   endtask

   task automatic test_negative_tie();
      frame = '{-9, -2, -8, -2, -7, -5, -6, -4, -3, -10, 0, 0, 0, 0, 0, 0};
      send_frame(10, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd1 || bus.out_score !== 32'hFFFF_FFFE || bus.out_error !== 1'b0) begin
         failures++;
         $display("FAIL negative_tie valid=%b class=%0d score=%h err=%b required 1/1/fffffffe/0", bus.out_valid, bus.out_class, bus.out_score, bus.out_error);
      end
      accept_result();
      checks++;
      if (frame_count !== 16'(exp_fc)) begin
         failures++;
         $display("FAIL negative_fc got=%0d required=%0d", frame_count, exp_fc);
      end
   endtask

   task automatic test_hold_stall();
      frame = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0};
      send_frame(10, 1'b1);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_class !== 4'd9 || bus.out_score !== 32'd7) begin
            failures++;
            $display("FAIL hold_stall cyc=%0d valid=%b ready=%b class=%0d score=%h required 1/0/9/7", c, bus.out_valid, bus.in_ready, bus.out_class, bus.out_score);
         end
      end
      accept_result();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || frame_count !== 16'(exp_fc)) begin
         failures++;
         $display("FAIL hold_release ready=%b valid=%b fc=%0d required 1/0/%0d", bus.in_ready, bus.out_valid, frame_count, exp_fc);
      end
   endtask

   task automatic test_short_frame();
      frame = '{0, 0, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      send_frame(5, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd2 || bus.out_score !== 32'd50 || bus.out_error !== 1'b1) begin
         failures++;
         $display("FAIL short_frame valid=%b class=%0d score=%h err=%b required 1/2/32/1", bus.out_valid, bus.out_class, bus.out_score, bus.out_error);
      end
      rd_idx = 4'd9; #1;
      checks++;
      if (rd_data !== 32'd7) begin
         failures++;
         $display("FAIL short_stale got=%h required=7", rd_data);
      end
      accept_result();
   endtask

   task automatic test_long_frame();
      frame = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 0, 0, 0, 0, 0};
      send_frame(10, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd9 || bus.out_score !== 32'd10 || bus.out_error !== 1'b1) begin
         failures++;
         $display("FAIL long_frame valid=%b class=%0d score=%h err=%b required 1/9/a/1", bus.out_valid, bus.out_class, bus.out_score, bus.out_error);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd100;
      bus.in_last  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL long_stall cyc=%0d ready=%b valid=%b required 0/1", c, bus.in_ready, bus.out_valid);
         end
      end
      accept_result();
      checks++;
      if (bus.in_ready !== 1'b1 || frame_count !== 16'(exp_fc)) begin
         failures++;
         $display("FAIL long_release ready=%b fc=%0d required 1/%0d", bus.in_ready, frame_count, exp_fc);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rd_idx = 4'd0; #1;
      checks++;
      if (rd_data !== 32'd100) begin
         failures++;
         $display("FAIL long_carry_beat got=%h required=64", rd_data);
      end
      frame = '{100, 1, 2, 3, 4, 5, 6, 7, 8, 3, 0, 0, 0, 0, 0, 0};
      for (int i = 1; i < 10; i++) begin
         send_beat(32'(frame[i]), i == 9);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd0 || bus.out_score !== 32'd100 || bus.out_error !== 1'b0) begin
         failures++;
         $display("FAIL long_next_frame valid=%b class=%0d score=%h err=%b required 1/0/64/0", bus.out_valid, bus.out_class, bus.out_score, bus.out_error);
      end
      accept_result();
   endtask

   task automatic test_midframe_reset();
      frame = '{1000, 900, 800, 700, 600, 500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      send_frame(6, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_fc = 0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || frame_count !== 16'd0) begin
         failures++;
         $display("FAIL midreset_state ready=%b valid=%b fc=%0d required 1/0/0", bus.in_ready, bus.out_valid, frame_count);
      end
      rd_idx = 4'd0; #1;
      checks++;
      if (rd_data !== 32'd0) begin
         failures++;
         $display("FAIL midreset_buffer got=%h required=0", rd_data);
      end
      frame = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 9; i++) begin
         send_beat(32'(frame[i]), 1'b0);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_early_end beat=%0d out_valid=%b required=0", i, bus.out_valid);
         end
      end
      send_beat(32'(frame[9]), 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd5 || bus.out_score !== 32'd9 || bus.out_error !== 1'b0) begin
         failures++;
         $display("FAIL midreset_frame valid=%b class=%0d score=%h err=%b required 1/5/9/0", bus.out_valid, bus.out_class, bus.out_score, bus.out_error);
      end
      accept_result();
      checks++;
      if (frame_count !== 16'(exp_fc)) begin
         failures++;
         $display("FAIL midreset_fc got=%0d required=%0d", frame_count, exp_fc);
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      exp_fc        = 0;
      rst           = 1'b0;
      rd_idx        = 4'd0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'd0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      test_reset();
      test_basic();
      test_negative_tie();
      test_hold_stall();
      test_short_frame();
      test_long_frame();
      test_midframe_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
